// File: rtl/wave_pkg.sv
// Shared types and constants for the wave engine.
//   mode_e    : waveform selector carried by the 3-bit mode input
//   LFSR_SEED : noise generator reset value
//   LFSR_TAPS : feedback taps 16,14,13,11 as a bit mask
package wave_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'b000,
    MODE_TRI   = 3'b001,
    MODE_SAW   = 3'b010,
    MODE_SQR   = 3'b011,
    MODE_NOISE = 3'b100
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/noise_lfsr.sv
// 16-bit Fibonacci LFSR noise source. It exists only when WAVE_ENGINE_NOISE_EN is defined.
// Ports:
//   clk   : clock, rising edge
//   nRst  : asynchronous active-low reset, loads LFSR_SEED
//   adv   : shift once this cycle
//   value : current LFSR state
`ifdef WAVE_ENGINE_NOISE_EN
module noise_lfsr
  import wave_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        adv,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      lfsr_q <= LFSR_SEED;
    end else if (adv) begin
      lfsr_q <= {lfsr_q[14:0], fb};
    end
  end

  assign value = lfsr_q;

endmodule
`endif

// File: rtl/wave_engine.sv
// Phase-accumulator waveform generator: triangle, sawtooth, square and optional noise,
// scaled by a volume setting and registered.
// Build option: define WAVE_ENGINE_NOISE_EN to include the LFSR noise source; without it
// mode 100 produces silence.
// Ports:
//   clk, nRst : clock (rising edge), asynchronous active-low reset
//   en        : advance phase by step this cycle
//   step      : phase increment
//   mode      : waveform select (sampled into a shadow register)
//   duty      : square-wave high threshold (shadowed)
//   volume    : amplitude scale, (volume+1)/2^VOL_W
//   wave_out  : registered sample
//   wrap      : one-cycle pulse after a phase overflow
module wave_engine
  import wave_pkg::*;
#(
  parameter int unsigned PH_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned VOL_W = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             en,
  input  logic [PH_W-1:0]  step,
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] duty,
  input  logic [VOL_W-1:0] volume,
  output logic [OUT_W-1:0] wave_out,
  output logic             wrap
);

  localparam int unsigned ProdW = OUT_W + VOL_W;

  logic [PH_W-1:0]  phase_q;
  logic [PH_W:0]    sum;
  logic             carry;
  mode_e            mode_q;
  logic [OUT_W-1:0] duty_q;
  logic [OUT_W-1:0] wave_q;
  logic             wrap_q;

  logic [OUT_W-1:0] p;
  logic [OUT_W-1:0] tri_base;
  logic [OUT_W-1:0] raw;
  logic [OUT_W-1:0] noise_raw;
  logic [VOL_W:0]   vol_p1;
  logic [ProdW-1:0] prod;
  logic [OUT_W-1:0] scaled;

  assign sum      = {1'b0, phase_q} + {1'b0, step};
  assign carry    = en & sum[PH_W];
  assign p        = phase_q[PH_W-1 -: OUT_W];
  assign tri_base = {p[OUT_W-2:0], 1'b0};

`ifdef WAVE_ENGINE_NOISE_EN
  logic [15:0]         lfsr_value;
  logic [16+OUT_W-1:0] lfsr_ext;

  // Noise advances once per period, on the same edge that raises wrap.
  noise_lfsr u_noise_lfsr (
    .clk  (clk),
    .nRst (nRst),
    .adv  (carry),
    .value(lfsr_value)
  );

  // Zero-extend below so OUT_W > 16 still elaborates.
  assign lfsr_ext  = {lfsr_value, {OUT_W{1'b0}}};
  assign noise_raw = lfsr_ext[16+OUT_W-1 -: OUT_W];
`else
  assign noise_raw = '0;
`endif

  always_comb begin
    raw = '0;
    case (mode_q)
      MODE_TRI:   raw = p[OUT_W-1] ? ~tri_base : tri_base;
      MODE_SAW:   raw = p;
      MODE_SQR:   raw = (p < duty_q) ? '1 : '0;
      MODE_NOISE: raw = noise_raw;
      default:    raw = '0;
    endcase
  end

  // Product is OUT_W+VOL_W wide: raw * 2^VOL_W at most, so nothing is lost.
  assign vol_p1 = {1'b0, volume} + {{VOL_W{1'b0}}, 1'b1};
  assign prod   = ProdW'(raw) * ProdW'(vol_p1);
  assign scaled = OUT_W'(prod >> VOL_W);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase_q <= '0;
      mode_q  <= MODE_OFF;
      duty_q  <= '0;
      wave_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      if (en) begin
        phase_q <= sum[PH_W-1:0];
      end
      wrap_q <= carry;
      // Shadow settings update only while idle or at a period boundary.
      if (!en || carry) begin
        mode_q <= mode_e'(mode);
        duty_q <= duty;
      end
      wave_q <= scaled;
    end
  end

  assign wave_out = wave_q;
  assign wrap     = wrap_q;

endmodule

// File: doc/wave_engine.md
WAVE_ENGINE -- requirements
Module: wave_engine

Interface
REQ-001 SHALL have parameter PH_W, default 16: phase accumulator width.
REQ-002 SHALL have parameter OUT_W, default 8: sample width, 4 <= OUT_W <= PH_W.
REQ-003 SHALL have parameter VOL_W, default 4: volume width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port nRst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1: advance phase this cycle.
REQ-007 SHALL have port step, input, PH_W: phase increment per enabled cycle.
REQ-008 SHALL have port mode, input, 3: 000 off, 001 triangle, 010 sawtooth, 011 square, 100 noise, others off.
REQ-009 SHALL have port duty, input, OUT_W: square high threshold.
REQ-010 SHALL have port volume, input, VOL_W: amplitude scale.
REQ-011 SHALL have port wave_out, output, OUT_W: registered sample.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse on phase overflow.

Function
REQ-013 Phase register: if en=1, phase <= phase + step (mod 2^PH_W); if en=0, phase holds.
REQ-014 wrap SHALL be registered; it is 1 in the cycle after an enabled add that carries out of PH_W bits, else 0; step=0 never wraps.
REQ-015 Shadow mode/duty registers SHALL load from inputs on every cycle with en=0, or on an enabled cycle whose add carries out; otherwise they hold, so changes while running take effect only at period boundary.
REQ-016 p = phase[PH_W-1 -: OUT_W], taken from current (pre-update) phase with shadow mode/duty.
REQ-017 Sawtooth raw = p.
REQ-018 Triangle raw = {p[OUT_W-2:0],0} when p MSB=0, else bitwise inverse of {p[OUT_W-2:0],0}.
REQ-019 Square raw = all-ones when p < duty, else 0; duty=0 gives constant 0.
REQ-020 Noise raw = top OUT_W bits of 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced once per wrap.
REQ-021 Off/unused modes: raw = 0.
REQ-022 Scaled = (raw * (volume+1)) >> VOL_W, full-width product, no overflow; volume all-ones passes raw unchanged.
REQ-023 wave_out <= scaled each cycle: one-cycle latency from phase to output; with en=0 output reflects held phase (stable).
REQ-024 Simultaneous wrap and input change: new shadow values used from the first sample of the new period.

Reset
REQ-025 nRst low SHALL asynchronously clear phase, wave_out, wrap, shadow mode (off), shadow duty to 0 and load LFSR with 16'hACE1.
REQ-026 Reset mid-period SHALL discard phase; first enabled cycle after release starts from phase 0.

Configuration
REQ-027 Macro WAVE_ENGINE_NOISE_EN defined: noise mode and LFSR present per REQ-020.
REQ-028 Macro undefined: no LFSR logic; mode 100 behaves as off (raw 0).

Structure
REQ-029 Package wave_pkg SHALL hold mode enum typedef (MODE_OFF, MODE_TRI, MODE_SAW, MODE_SQR, MODE_NOISE), LFSR seed and tap constants.
REQ-030 LFSR SHALL be sub-module noise_lfsr (ports clk, nRst, adv, value[15:0]), instantiated only under WAVE_ENGINE_NOISE_EN.

Verification (PH_W=16, OUT_W=8, VOL_W=4)
REQ-031 Saw, step=256, volume=15, en=1 from reset: wave_out = 0,0,1,2,...,255 then 0; wrap pulses once every 256 cycles.
REQ-032 Triangle, step=256: p=0x40 -> 0x80, p=0x7F -> 0xFE, p=0xC0 -> 0x7F, p=0xFF -> 0x01.
REQ-033 Square, duty=0x40, step=256: 64 samples 0xFF then 192 samples 0x00; volume=7 gives 0x7F instead of 0xFF.
REQ-034 Mode saw->square at p=0x80 while en=1: saw continues to 0xFF, square starts at next wrap; with en=0, change applies next cycle.
REQ-035 nRst pulsed at p=0x55: wave_out, wrap 0 immediately; restart from 0; en=0 with step=1000 holds output constant.
REQ-036 Noise (macro on), step=0x8000: LFSR advances every 2 cycles, first value after seed 0xACE1 checked vs model; macro off: mode 100 -> wave_out 0.
